// File: rtl/period_meter_if.sv
// period_meter_if: enable/input and measurement-result bundle for period_meter
interface period_meter_if #(
    parameter int unsigned WIDTH = 26
);
    logic             i_en;
    logic             i_sig_in;
    logic [WIDTH-1:0] o_period;
    logic [WIDTH-1:0] o_high_time;
    logic             o_valid;
    logic             o_no_sig;

    modport master (
        output i_en, i_sig_in,
        input  o_period, o_high_time, o_valid, o_no_sig
    );

    modport slave (
        input  i_en, i_sig_in,
        output o_period, o_high_time, o_valid, o_no_sig
    );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures period and high time of an external square wave in clock cycles; PERIOD_METER_DEGLITCH_EN adds a FILTER_CYCLES input deglitcher
module period_meter #(
    parameter int unsigned      WIDTH   = 26,
    parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(50_000_000)
`ifdef PERIOD_METER_DEGLITCH_EN
    ,
    parameter int unsigned      FILTER_CYCLES = 4
`endif
) (
    input logic           i_clk,
    input logic           i_clr_n,
    period_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_s1, r_s2, r_d;
    logic             w_lvl, w_rise, w_fall, w_tmo, w_upd, w_dead, w_meas;
    logic [WIDTH-1:0] r_cnt, r_hi, r_period, r_high;
    logic             r_valid, r_no_sig;

    // Two-flop synchronizer plus the one-cycle delay used for edge detection
    always_ff @(posedge i_clk or negedge i_clr_n)
        if (!i_clr_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_s1 <= bus.i_sig_in;
            r_s2 <= r_s1;
            r_d  <= w_lvl;
        end

`ifdef PERIOD_METER_DEGLITCH_EN
    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);

    logic          r_f;
    logic [FW-1:0] r_fc;

    // Filtered level follows sig_s only after FILTER_CYCLES consecutive disagreeing samples
    always_ff @(posedge i_clk or negedge i_clr_n)
        if (!i_clr_n) begin
            r_f  <= 1'b0;
            r_fc <= '0;
        end else if (r_s2 == r_f) begin
            r_fc <= '0;
        end else if (r_fc == FW'(FILTER_CYCLES - 1)) begin
            r_f  <= r_s2;
            r_fc <= '0;
        end else begin
            r_fc <= r_fc + FW'(1);
        end

    assign w_lvl = r_f;
`else
    assign w_lvl = r_s2;
`endif

    assign w_rise = w_lvl & ~r_d;
    assign w_fall = ~w_lvl & r_d;
    assign w_tmo  = r_cnt == TIMEOUT;

    // State register
    always_ff @(posedge i_clk or negedge i_clr_n)
        if (!i_clr_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;

    // Next state and strobes: EN low wins, then a rise, then the timeout
    always_comb begin
        w_state_nxt = !bus.i_en ? IDLE :
                      (r_state == IDLE) ? ARMED :
                      w_rise ? MEASURE :
                      w_tmo ? ARMED : r_state;
        w_meas = bus.i_en && r_state == MEASURE;
        w_upd  = w_meas && w_rise;
        w_dead = bus.i_en && r_state != IDLE && !w_rise && w_tmo;
    end

    // Shared cycle/wait counter, high-phase capture and result registers
    always_ff @(posedge i_clk or negedge i_clr_n)
        if (!i_clr_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_no_sig <= 1'b0;
        end else begin
            r_valid <= w_upd;
            if (!bus.i_en || r_state == IDLE) r_cnt <= '0;
            else if (w_rise)                  r_cnt <= WIDTH'(1);
            else if (w_tmo)                   r_cnt <= '0;
            else                              r_cnt <= (&r_cnt) ? r_cnt : r_cnt + WIDTH'(1);
            if (w_meas && w_fall) r_hi <= r_cnt;
            if (w_upd) begin
                r_period <= r_cnt;
                r_high   <= r_hi;
                r_no_sig <= 1'b0;
            end else if (w_dead) begin
                r_period <= '0;
                r_high   <= '0;
                r_no_sig <= 1'b1;
            end
        end

    assign bus.o_period    = r_period;
    assign bus.o_high_time = r_high;
    assign bus.o_valid     = r_valid;
    assign bus.o_no_sig    = r_no_sig;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized scoreboard bench for period_meter
module tb_period_meter;
    localparam int W = 26;
    localparam int T = 100;
`ifdef PERIOD_METER_DEGLITCH_EN
    localparam int LAT = 7;
    localparam bit DG  = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DG  = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    period_meter_if #(.WIDTH(W)) bus();

    period_meter #(.WIDTH(W), .TIMEOUT(W'(T))) dut (
        .i_clk  (clk),
        .i_clr_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc = 0, last_rise = 0, last_fall = 0;
    bit lvl = 1'b0, started = 1'b0, en_m = 1'b0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] obs[$];
    logic [2*W-1:0] got, want;

    always @(negedge clk)
        if (rst_n && bus.o_valid) obs.push_back({bus.o_period, bus.o_high_time});

    task automatic put(input bit v, input bit seen = 1'b1);
        bus.i_sig_in = v;
        if (seen && v && !lvl && en_m) begin
            if (started && cyc - last_rise <= T)
                exp_q.push_back({W'(cyc - last_rise), W'(last_fall - last_rise)});
            started   = 1'b1;
            last_rise = cyc;
        end
        if (seen && !v && lvl) last_fall = cyc;
        if (seen) lvl = v;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int p, input int h, input bit seen = 1'b1);
        repeat (h) put(1'b1, seen);
        repeat (p - h) put(1'b0, seen);
    endtask

    task automatic set_en(input bit v);
        bus.i_en = v;
        en_m     = v;
        if (!v) started = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig} !== '0) begin
            fails++;
            $display("FAIL reset_async got=%0d/%0d/%0b/%0b want=0", bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig} !== '0) begin
            fails++;
            $display("FAIL reset_hold got=%0d/%0d/%0b/%0b want=0", bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig);
        end
        set_en(1'b1);
        for (int k = 1; k <= T + 2; k++) begin
            put(1'b0);
            if (k == T + 1) begin
                checks++;
                if (bus.o_no_sig !== 1'b0) begin
                    fails++;
                    $display("FAIL armed_nosig_early got=%0b want=0", bus.o_no_sig);
                end
            end
            if (k == T + 2) begin
                checks++;
                if (bus.o_no_sig !== 1'b1) begin
                    fails++;
                    $display("FAIL armed_nosig got=%0b want=1", bus.o_no_sig);
                end
            end
        end
    endtask

    task automatic test_square;
        repeat (8) wave(10, 5);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (bus.o_no_sig !== 1'b0) begin
            fails++;
            $display("FAIL square_nosig got=%0b want=0", bus.o_no_sig);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL square_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL square_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_duty;
        repeat (8) wave(7, 2, !DG);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL duty_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL duty_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_timeout;
        repeat (3) wave(20, 10);
        for (int k = 1; k <= T + LAT; k++) begin
            put(k <= 10);
            if (k == T + LAT - 1) begin
                checks++;
                if (bus.o_no_sig !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_early got=%0b want=0", bus.o_no_sig);
                end
            end
        end
        checks++;
        if ({bus.o_no_sig, bus.o_period, bus.o_high_time} !== {1'b1, {2*W{1'b0}}}) begin
            fails++;
            $display("FAIL timeout_dead got=%0b/%0d/%0d want=1/0/0", bus.o_no_sig, bus.o_period, bus.o_high_time);
        end
        repeat (3) wave(20, 10);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (bus.o_no_sig !== 1'b0) begin
            fails++;
            $display("FAIL timeout_resume got=%0b want=0", bus.o_no_sig);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL timeout_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL timeout_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_enable;
        repeat (3) wave(14, 6);
        repeat (6) put(1'b1);
        repeat (4) put(1'b0);
        set_en(1'b0);
        repeat (3) put(1'b0);
        checks++;
        if ({bus.o_period, bus.o_high_time} !== {W'(14), W'(6)}) begin
            fails++;
            $display("FAIL enable_hold got=%0d/%0d want=14/6", bus.o_period, bus.o_high_time);
        end
        set_en(1'b1);
        repeat (3) put(1'b0);
        repeat (4) wave(9, 4);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL enable_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL enable_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_clr;
        repeat (3) wave(16, 8);
        repeat (8) put(1'b1);
        repeat (4) put(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig} !== '0) begin
            fails++;
            $display("FAIL clr_async got=%0d/%0d/%0b/%0b want=0", bus.o_period, bus.o_high_time, bus.o_valid, bus.o_no_sig);
        end
        started = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) wave(10, 5);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL clr_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL clr_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_glitch;
        repeat (4) begin
            repeat (20) put(1'b1);
            repeat (8) put(1'b0);
            repeat (2) put(1'b1, !DG);
            repeat (10) put(1'b0);
        end
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL glitch_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL glitch_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        int p, h;
        repeat (20) begin
            p = $urandom_range(60, 8);
            h = $urandom_range(p - 4, 4);
            wave(p, h);
        end
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL random_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_boundary;
        repeat (2) wave(T, T / 2);
        repeat (2) wave(T + 1, T / 2);
        repeat (LAT + 2) put(1'b0);
        checks++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL boundary_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            got = obs.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL boundary_result got=%0d/%0d want=%0d/%0d", got[2*W-1:W], got[W-1:0], want[2*W-1:W], want[W-1:0]);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    initial begin
        bus.i_en     = 1'b0;
        bus.i_sig_in = 1'b0;
        test_reset();
        test_square();
        test_duty();
        test_timeout();
        test_enable();
        test_clr();
        test_glitch();
        test_random();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
